// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch stage: data width,
// PC-select encodings and FSM state encodings.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the TRAP_S state).
package fetch_sequencer_pkg;

    localparam int FETCH_WORD_SIZE = 32;

    // Next-PC source selected by the decoder.
    localparam logic [1:0] PCSEL_PCPLUSFOUR = 2'd0;
    localparam logic [1:0] PCSEL_PCOFFSET   = 2'd1;
    localparam logic [1:0] PCSEL_REGOFFSET  = 2'd2;

    typedef enum logic [2:0] {
        FETCH_S    = 3'd0,
        WAIT_MEM_S = 3'd1,
        ISSUE_S    = 3'd2,
        RESOLVE_S  = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        TRAP_S     = 3'd4
`endif
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC computation. Kept free of any fetch-FSM state so a
// pipelined core can reuse it directly. All arithmetic wraps modulo 2^WORD_SIZE.
module next_pc_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int WORD_SIZE = FETCH_WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [1:0]           pc_sel,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] imm,
    input  logic [WORD_SIZE-1:0] reg_base,
    output logic [WORD_SIZE-1:0] next_pc,
    output logic                 misaligned
);

    logic [WORD_SIZE-1:0] pc_plus_four;
    logic [WORD_SIZE-1:0] imm_words;

    assign pc_plus_four = pc + WORD_SIZE'(4);
    assign imm_words    = imm << 2;

    // Select the next PC; any unknown select falls back to sequential fetch.
    always_comb begin
        next_pc = pc_plus_four;
        case (pc_sel)
            PCSEL_PCPLUSFOUR: next_pc = pc_plus_four;
            PCSEL_PCOFFSET:   next_pc = branch_taken ? (pc_plus_four + imm_words) : pc_plus_four;
            PCSEL_REGOFFSET:  next_pc = reg_base + imm_words;
            default:          next_pc = pc_plus_four;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: one instruction in flight, req/ack to
// instruction memory, valid/ready to the decoder, PC update on resolve.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a misaligned next PC freezes the PC, raises misalign and
//               parks the FSM in TRAP_S until reset.
//   undefined - next PC is forced word aligned; misalign is tied low.
//
// state      | meaning
// -----------+----------------------------------------------------------
// FETCH_S    | raise imem_req for the current pc
// WAIT_MEM_S | request outstanding, waiting for imem_ack
// ISSUE_S    | instr_out valid, waiting for instr_ready
// RESOLVE_S  | instruction accepted, waiting for resolve_valid
// TRAP_S     | misaligned target seen; idle until reset (trap build only)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                   WORD_SIZE = FETCH_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] instr_out,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [WORD_SIZE-1:0] pc_out,
    input  logic                 resolve_valid,
    input  logic [1:0]           pc_sel,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] imm,
    input  logic [WORD_SIZE-1:0] reg_base,
    output logic                 misalign
);

    fetch_state_t         state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] next_pc;
    logic                 next_misaligned;
    logic                 resolve_fire;

    next_pc_calc #(
        .WORD_SIZE (WORD_SIZE)
    ) u_next_pc_calc (
        .pc           (pc),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .imm          (imm),
        .reg_base     (reg_base),
        .next_pc      (next_pc),
        .misaligned   (next_misaligned)
    );

    assign imem_addr = pc;

    // A resolve is taken either in RESOLVE_S or together with the decoder
    // handshake, so single-cycle execute skips RESOLVE_S entirely.
    assign resolve_fire = resolve_valid &&
                          ((state == RESOLVE_S) || ((state == ISSUE_S) && instr_ready));

`ifndef FETCH_MISALIGN_TRAP_EN
    logic [WORD_SIZE-1:0] next_pc_aligned;

    assign next_pc_aligned = next_misaligned ? {next_pc[WORD_SIZE-1:2], 2'b00} : next_pc;
    assign misalign        = 1'b0;
`endif

    // Fetch FSM with registered handshake outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH_S;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            pc_out      <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH_S: begin
                    imem_req <= 1'b1;
                    state    <= WAIT_MEM_S;
                end
                WAIT_MEM_S: begin
                    if (imem_ack) begin
                        instr_out   <= imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ISSUE_S;
                    end
                end
                ISSUE_S: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= RESOLVE_S;
                    end
                end
                RESOLVE_S: begin
                    state <= RESOLVE_S;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                TRAP_S: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
`endif
                default: begin
                    state <= FETCH_S;
                end
            endcase

            if (resolve_fire) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (next_misaligned) begin
                    misalign <= 1'b1;
                    state    <= TRAP_S;
                end else begin
                    pc    <= next_pc;
                    state <= FETCH_S;
                end
`else
                pc    <= next_pc_aligned;
                state <= FETCH_S;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by a
// randomized instruction stream, checked against a transaction-level PC model.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;
    logic        resolve_valid;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] reg_base;
    logic        misalign;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_instrs = 0;
    int          req_rises = 0;
    logic        req_q = 1'b0;
    logic [31:0] model_pc;

    fetch_sequencer #(
        .WORD_SIZE (32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_out        (pc_out),
        .resolve_valid (resolve_valid),
        .pc_sel        (pc_sel),
        .branch_taken  (branch_taken),
        .imm           (imm),
        .reg_base      (reg_base),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    // Count memory requests so each instruction can be matched to exactly one fetch.
    always @(negedge clk) begin
        if (imem_req && !req_q) req_rises++;
        req_q = imem_req;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Target address from the branch/jump rules, word-aligned in the default build.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] sel,
                                               input logic bt, input logic [31:0] imm_v,
                                               input logic [31:0] base_v);
        logic [31:0] t;
        if (sel == PCSEL_PCOFFSET && bt) t = cur + 32'd4 + imm_v * 32'd4;
        else if (sel == PCSEL_REGOFFSET) t = base_v + imm_v * 32'd4;
        else                             t = cur + 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
        t = t & ~32'd3;
`endif
        return t;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_val("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_instr(input int ack_dly, input int rdy_dly, input bit same_cycle,
                             input int res_dly, input logic [1:0] sel, input logic bt,
                             input logic [31:0] imm_v, input logic [31:0] base_v,
                             input logic [31:0] rdata_v);
        bit          ok;
        logic [31:0] exp_next;
        wait_req(ok);
        if (!ok) return;
        n_instrs++;
        check_val("fetch_addr", imem_addr, model_pc);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            check_val("addr_stable", imem_addr, model_pc);
            check_val("req_held", imem_req, 1);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata_v;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check_val("instr_valid", instr_valid, 1);
        check_val("instr_out", instr_out, rdata_v);
        check_val("pc_out", pc_out, model_pc);
        check_val("req_drop", imem_req, 0);
        for (int i = 0; i < rdy_dly; i++) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clk);
            check_val("valid_hold", instr_valid, 1);
            check_val("instr_hold", instr_out, rdata_v);
        end
        imem_ack = 1'b0;
        exp_next = model_next(model_pc, sel, bt, imm_v, base_v);
        instr_ready = 1'b1;
        if (same_cycle) begin
            pc_sel = sel; branch_taken = bt; imm = imm_v; reg_base = base_v;
            resolve_valid = 1'b1;
        end
        @(negedge clk);
        instr_ready   = 1'b0;
        resolve_valid = 1'b0;
        check_val("valid_drop", instr_valid, 0);
        if (!same_cycle) begin
            for (int i = 0; i < res_dly; i++) begin
                imem_ack = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
                pc_sel = 2'($urandom_range(0, 3)); imm = $urandom; reg_base = $urandom;
                @(negedge clk);
                check_val("no_refetch", imem_req, 0);
                check_val("no_stray_valid", instr_valid, 0);
            end
            imem_ack = 1'b0;
            pc_sel = sel; branch_taken = bt; imm = imm_v; reg_base = base_v;
            resolve_valid = 1'b1;
            @(negedge clk);
            resolve_valid = 1'b0;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        if (exp_next[1:0] != 2'b00) begin
            check_val("misalign_set", misalign, 1);
        end else begin
            check_val("misalign_low", misalign, 0);
            model_pc = exp_next;
        end
`else
        check_val("misalign_low", misalign, 0);
        model_pc = exp_next;
`endif
    endtask

    initial begin
        bit ok;
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        resolve_valid = 1'b0; pc_sel = PCSEL_PCPLUSFOUR; branch_taken = 1'b0;
        imm = '0; reg_base = '0;
        model_pc = 32'h0;
        repeat (3) @(negedge clk);
        check_val("rst_req", imem_req, 0);
        check_val("rst_valid", instr_valid, 0);
        check_val("rst_instr", instr_out, 0);
        check_val("rst_addr", imem_addr, 0);
        check_val("rst_misalign", misalign, 0);
        reset = 1'b0;

        // Sequential fetch with single-cycle memory and execute.
        run_instr(0, 0, 1, 0, PCSEL_PCPLUSFOUR, 0, 0, 0, 32'h1234_5678);
        run_instr(0, 0, 1, 0, PCSEL_PCPLUSFOUR, 0, 0, 0, 32'h1234_5678);
        run_instr(0, 0, 1, 0, PCSEL_PCPLUSFOUR, 0, 0, 0, 32'h1234_5678);
        run_instr(0, 0, 1, 0, PCSEL_PCPLUSFOUR, 0, 0, 0, 32'h1234_5678);
        // Branches at 0x10 with imm=-2: taken -> 0x0C, not taken -> 0x14.
        run_instr(0, 0, 1, 0, PCSEL_PCOFFSET, 1, 32'hFFFF_FFFE, 0, 32'hB000_0001);
        check_val("branch_taken_pc", model_pc, 32'h0C);
        run_instr(0, 0, 1, 0, PCSEL_PCPLUSFOUR, 0, 0, 0, 32'hB000_0002);
        run_instr(0, 0, 0, 1, PCSEL_PCOFFSET, 0, 32'hFFFF_FFFE, 0, 32'hB000_0003);
        // Register-relative jump: 0x100 + 3*4.
        run_instr(1, 0, 1, 0, PCSEL_REGOFFSET, 0, 32'd3, 32'h100, 32'hCAFE_0001);
        // Slow memory and stalled decoder.
        run_instr(5, 3, 0, 2, PCSEL_PCPLUSFOUR, 0, 0, 0, 32'hCAFE_0002);
        // Wrap-around at the top of the address space.
        run_instr(0, 0, 1, 0, PCSEL_REGOFFSET, 0, 32'd0, 32'hFFFF_FFFC, 32'hCAFE_0003);
        run_instr(0, 0, 1, 0, PCSEL_PCPLUSFOUR, 0, 0, 0, 32'hCAFE_0004);
        run_instr(0, 0, 1, 0, PCSEL_PCPLUSFOUR, 0, 0, 0, 32'hCAFE_0005);

        // Reset while the memory request is outstanding.
        wait_req(ok);
        n_instrs++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_pc = 32'h0;
        check_val("rstw_req", imem_req, 0);
        check_val("rstw_valid", instr_valid, 0);
        check_val("rstw_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check_val("rstw_late_ack", instr_valid, 0);

        // Reset while an instruction is waiting for the decoder.
        wait_req(ok);
        n_instrs++;
        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        imem_ack = 1'b0;
        check_val("rsti_valid_before", instr_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rsti_valid", instr_valid, 0);
        check_val("rsti_req", imem_req, 0);
        check_val("rsti_addr", imem_addr, 32'h0);
        check_val("rsti_instr", instr_out, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check_val("rsti_late_ack", instr_valid, 0);

        // Misaligned register target 0x102.
        run_instr(0, 0, 1, 0, PCSEL_REGOFFSET, 0, 32'd0, 32'h102, 32'h0BAD_0001);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("trap_no_req", imem_req, 0);
            check_val("trap_no_valid", instr_valid, 0);
            check_val("trap_misalign", misalign, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_pc = 32'h0;
        check_val("trap_rst_misalign", misalign, 0);
`else
        check_val("align_forced_pc", model_pc, 32'h100);
        run_instr(0, 0, 1, 0, PCSEL_PCPLUSFOUR, 0, 0, 0, 32'h0BAD_0002);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] base_r;
            base_r = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            base_r[1:0] = 2'b00;
`endif
            run_instr($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom, base_r, $urandom);
        end

        @(negedge clk);
        check_val("fetch_count", req_rises, n_instrs);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
